// File: rtl/fust_g_table.sv
// Issue queue of NROWS rows with tag wakeup and oldest-first selection; dispatch and issue are combinational offers, so state changes at the next edge.
// Dispatch back-pressures via disp_ready when full; issue offers are held while iss_ready is low.
module fust_g_table #(
  parameter int NROWS = 4,
  parameter int OPW   = 4,
  parameter int REGW  = 5,
  parameter int TAGW  = 4,
  localparam int IDXW = $clog2(NROWS),
  localparam int ROWW = OPW + 3*REGW + 2*TAGW
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            disp_en,
  input  logic [ROWW-1:0] disp_row,
  input  logic            disp_r1,
  input  logic            disp_r2,
  output logic            disp_ready,
  output logic [IDXW-1:0] disp_idx,
  input  logic            wb_en,
  input  logic [TAGW-1:0] wb_tag,
  output logic            iss_valid,
  input  logic            iss_ready,
  output logic [IDXW-1:0] iss_idx,
  output logic [ROWW-1:0] iss_row,
  input  logic            flush,
  output logic [NROWS-1:0] busy
);

  localparam logic [IDXW-1:0] AGE_MAX = IDXW'(NROWS - 1);

  logic [ROWW-1:0]  pay_q [NROWS];
  logic [IDXW-1:0]  age_q [NROWS];
  logic [IDXW-1:0]  age_d [NROWS];
  logic [NROWS-1:0] busy_q, r1_q, r2_q, elig, older;
  logic [IDXW-1:0]  best_age;
  logic             found;
  logic             do_disp, do_iss;
  logic             disp_w1, disp_w2;

  assign busy       = busy_q;
  assign disp_ready = |(~busy_q);
  assign elig       = busy_q & r1_q & r2_q;
  assign iss_valid  = |elig;
  assign iss_row    = iss_valid ? pay_q[iss_idx] : '0;
  assign do_disp    = disp_en & disp_ready;
  assign do_iss     = iss_valid & iss_ready;

  // Same-cycle writeback bypass into the row being dispatched.
  assign disp_w1 = disp_r1 | (wb_en && disp_row[2*TAGW-1:TAGW] == wb_tag);
  assign disp_w2 = disp_r2 | (wb_en && disp_row[TAGW-1:0] == wb_tag);

  always_comb begin
    disp_idx = '0;
    for (int i = NROWS - 1; i >= 0; i--) begin
      if (!busy_q[i]) disp_idx = IDXW'(i);
    end
  end

  always_comb begin
    iss_idx  = '0;
    best_age = '0;
    found    = 1'b0;
    for (int i = 0; i < NROWS; i++) begin
      if (elig[i] && (!found || age_q[i] > best_age)) begin
        iss_idx  = IDXW'(i);
        best_age = age_q[i];
        found    = 1'b1;
      end
    end
  end

  // Age is the row's rank among busy rows (0 = youngest). Rows older than an
  // issued row step down so ranks stay dense and unique; saturation then never
  // collapses two rows onto the same age.
  always_comb begin
    older = '0;
    for (int i = 0; i < NROWS; i++) begin
      age_d[i] = age_q[i];
      older[i] = do_iss && (age_q[i] > age_q[iss_idx]);
      if (do_disp && !older[i] && age_q[i] != AGE_MAX)
        age_d[i] = age_q[i] + 1'b1;
      else if (!do_disp && older[i])
        age_d[i] = age_q[i] - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      for (int i = 0; i < NROWS; i++) begin
        age_q[i] <= '0;
        pay_q[i] <= '0;
      end
    end else if (flush) begin
      busy_q <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      for (int i = 0; i < NROWS; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NROWS; i++) begin
        age_q[i] <= age_d[i];
        if (wb_en && busy_q[i] && pay_q[i][2*TAGW-1:TAGW] == wb_tag) r1_q[i] <= 1'b1;
        if (wb_en && busy_q[i] && pay_q[i][TAGW-1:0] == wb_tag)      r2_q[i] <= 1'b1;
      end
      if (do_iss) busy_q[iss_idx] <= 1'b0;
      // The dispatch row is never busy, so it cannot collide with the issued row.
      if (do_disp) begin
        pay_q[disp_idx]  <= disp_row;
        busy_q[disp_idx] <= 1'b1;
        age_q[disp_idx]  <= '0;
        r1_q[disp_idx]   <= disp_w1;
        r2_q[disp_idx]   <= disp_w2;
      end
    end
  end

endmodule

// File: tb/tb_fust_g_table.sv
// Directed bench for fust_g_table: fill, wakeup, oldest-first, bypass, stall, flush and reset.
module tb_fust_g_table;
  localparam int NROWS = 4;
  localparam int IDXW  = 2;
  localparam int ROWW  = 27;

  logic            CLK, RST;
  logic            disp_en, disp_r1, disp_r2, disp_ready;
  logic [ROWW-1:0] disp_row;
  logic [IDXW-1:0] disp_idx, iss_idx;
  logic            wb_en, iss_valid, iss_ready, flush;
  logic [3:0]      wb_tag;
  logic [ROWW-1:0] iss_row;
  logic [NROWS-1:0] busy;

  int checks = 0;
  int errors = 0;

  logic [ROWW-1:0] ra, rb, rx, ry, rz, rn;
  logic [ROWW-1:0] rows [4];

  fust_g_table dut (
    .CLK(CLK), .RST(RST),
    .disp_en(disp_en), .disp_row(disp_row), .disp_r1(disp_r1), .disp_r2(disp_r2),
    .disp_ready(disp_ready), .disp_idx(disp_idx),
    .wb_en(wb_en), .wb_tag(wb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_idx(iss_idx), .iss_row(iss_row),
    .flush(flush), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [ROWW-1:0] mkrow(input logic [3:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [3:0] t1, input logic [3:0] t2);
    return {op, rd, rs1, rs2, t1, t2};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy"},       64'(busy), 64'(0));
    chk({tag, " disp_ready"}, 64'(disp_ready), 64'(1));
    chk({tag, " disp_idx"},   64'(disp_idx), 64'(0));
    chk({tag, " iss_valid"},  64'(iss_valid), 64'(0));
    chk({tag, " iss_idx"},    64'(iss_idx), 64'(0));
    chk({tag, " iss_row"},    64'(iss_row), 64'(0));
  endtask

  initial begin
    RST = 1'b1; disp_en = 1'b0; disp_row = '0; disp_r1 = 1'b0; disp_r2 = 1'b0;
    wb_en = 1'b0; wb_tag = '0; iss_ready = 1'b0; flush = 1'b0;
    #1;
    chk_reset_outputs("reset");
    tick; tick;
    RST = 1'b0;

    // Fill with non-ready rows, then a fifth request must be ignored.
    for (int k = 0; k < 4; k++) begin
      disp_en = 1'b1;
      disp_row = mkrow(4'(k), 5'(k + 1), 5'd2, 5'd3, 4'd1, 4'd2);
      chk("fill disp_idx", 64'(disp_idx), 64'(k));
      chk("fill disp_ready", 64'(disp_ready), 64'(1));
      tick;
    end
    chk("fill busy", 64'(busy), 64'hF);
    chk("fill disp_ready full", 64'(disp_ready), 64'(0));
    disp_row = mkrow(4'hF, 5'd31, 5'd31, 5'd31, 4'hF, 4'hF);
    tick;
    disp_en = 1'b0;
    chk("fifth ignored busy", 64'(busy), 64'hF);
    chk("fifth ignored iss_valid", 64'(iss_valid), 64'(0));
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush clears busy", 64'(busy), 64'(0));

    // Two-step wakeup of row 0.
    ra = mkrow(4'd5, 5'd10, 5'd11, 5'd12, 4'd3, 4'd5);
    disp_en = 1'b1; disp_row = ra;
    chk("wakeup disp_idx", 64'(disp_idx), 64'(0));
    tick;
    disp_en = 1'b0; wb_en = 1'b1; wb_tag = 4'd3;
    tick;
    chk("wakeup half iss_valid", 64'(iss_valid), 64'(0));
    wb_tag = 4'd5;
    chk("wakeup before edge", 64'(iss_valid), 64'(0));
    tick;
    wb_en = 1'b0;
    chk("wakeup iss_valid", 64'(iss_valid), 64'(1));
    chk("wakeup iss_idx", 64'(iss_idx), 64'(0));
    chk("wakeup iss_row", 64'(iss_row), 64'(ra));
    iss_ready = 1'b1;
    tick;
    iss_ready = 1'b0;
    chk("wakeup issued busy", 64'(busy), 64'(0));
    chk("wakeup issued iss_row", 64'(iss_row), 64'(0));

    // Oldest-first: ready rows land in 2, 0, 1 (with same-cycle issue+dispatch).
    disp_r1 = 1'b1; disp_r2 = 1'b1; disp_en = 1'b1;
    disp_row = mkrow(4'd1, 5'd1, 5'd0, 5'd0, 4'd0, 4'd0); tick;
    disp_row = mkrow(4'd2, 5'd2, 5'd0, 5'd0, 4'd0, 4'd0); tick;
    rx = mkrow(4'd3, 5'd3, 5'd0, 5'd0, 4'd0, 4'd0);
    disp_row = rx;
    chk("oldest X disp_idx", 64'(disp_idx), 64'(2));
    tick;
    disp_en = 1'b0; iss_ready = 1'b1;
    chk("oldest filler0", 64'(iss_idx), 64'(0));
    tick;
    ry = mkrow(4'd4, 5'd4, 5'd0, 5'd0, 4'd0, 4'd0);
    disp_en = 1'b1; disp_row = ry;
    chk("oldest filler1", 64'(iss_idx), 64'(1));
    chk("oldest Y disp_idx", 64'(disp_idx), 64'(0));
    tick;
    rz = mkrow(4'd6, 5'd6, 5'd0, 5'd0, 4'd0, 4'd0);
    disp_row = rz;
    chk("oldest first X", 64'(iss_idx), 64'(2));
    chk("oldest first X row", 64'(iss_row), 64'(rx));
    chk("oldest Z disp_idx", 64'(disp_idx), 64'(1));
    tick;
    disp_en = 1'b0;
    chk("oldest second Y", 64'(iss_idx), 64'(0));
    chk("oldest second Y row", 64'(iss_row), 64'(ry));
    tick;
    chk("oldest third Z", 64'(iss_idx), 64'(1));
    chk("oldest third Z row", 64'(iss_row), 64'(rz));
    tick;
    iss_ready = 1'b0;
    chk("oldest drained", 64'(iss_valid), 64'(0));
    chk("oldest drained busy", 64'(busy), 64'(0));

    // Bypass: t1 woken by a writeback in the dispatch cycle.
    rb = mkrow(4'd7, 5'd7, 5'd1, 5'd2, 4'd7, 4'd9);
    disp_en = 1'b1; disp_row = rb; disp_r1 = 1'b0; disp_r2 = 1'b1;
    wb_en = 1'b1; wb_tag = 4'd7;
    tick;
    chk("bypass iss_valid", 64'(iss_valid), 64'(1));
    chk("bypass iss_idx", 64'(iss_idx), 64'(0));
    chk("bypass iss_row", 64'(iss_row), 64'(rb));
    disp_row = mkrow(4'd8, 5'd8, 5'd1, 5'd2, 4'd7, 4'd9);
    wb_tag = 4'd6;
    tick;
    disp_en = 1'b0; wb_en = 1'b0; iss_ready = 1'b1;
    chk("no bypass busy", 64'(busy), 64'h3);
    chk("no bypass oldest", 64'(iss_idx), 64'(0));
    tick;
    iss_ready = 1'b0;
    chk("no bypass not eligible", 64'(iss_valid), 64'(0));
    flush = 1'b1; disp_en = 1'b1; disp_r1 = 1'b1;
    tick;
    flush = 1'b0; disp_en = 1'b0;
    chk("flush+disp busy", 64'(busy), 64'(0));
    chk("flush+disp iss_valid", 64'(iss_valid), 64'(0));

    // Stall with a full table, then issue frees a row for the next dispatch.
    disp_r1 = 1'b1; disp_r2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rows[k] = mkrow(4'(k + 8), 5'(k + 20), 5'd4, 5'd5, 4'd0, 4'd0);
      disp_en = 1'b1; disp_row = rows[k];
      tick;
    end
    disp_en = 1'b0;
    chk("stall full busy", 64'(busy), 64'hF);
    for (int k = 0; k < 3; k++) begin
      chk("stall iss_valid", 64'(iss_valid), 64'(1));
      chk("stall iss_idx", 64'(iss_idx), 64'(0));
      chk("stall iss_row", 64'(iss_row), 64'(rows[0]));
      tick;
    end
    rn = mkrow(4'd12, 5'd30, 5'd6, 5'd7, 4'd0, 4'd0);
    iss_ready = 1'b1; disp_en = 1'b1; disp_row = rn;
    chk("stall disp rejected", 64'(disp_ready), 64'(0));
    tick;
    iss_ready = 1'b0;
    chk("freed busy", 64'(busy), 64'hE);
    chk("freed disp_idx", 64'(disp_idx), 64'(0));
    tick;
    disp_en = 1'b0;
    chk("refill busy", 64'(busy), 64'hF);
    chk("refill oldest", 64'(iss_idx), 64'(1));
    chk("refill oldest row", 64'(iss_row), 64'(rows[1]));

    // Asynchronous reset in mid-cycle.
    #2;
    RST = 1'b1;
    #1;
    chk_reset_outputs("async reset");
    tick;
    RST = 1'b0; iss_ready = 1'b1;
    tick;
    iss_ready = 1'b0;
    chk("post reset iss_valid", 64'(iss_valid), 64'(0));
    chk("post reset busy", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fust_g_table.md
FUST_G_TABLE -- requirements
Module: fust_g_table

Interface -- parameters
REQ-001 SHALL have parameter NROWS, default 4, meaning number of FUST rows (power of two, >=2).
REQ-002 SHALL have parameter OPW, default 4, meaning opcode field width.
REQ-003 SHALL have parameter REGW, default 5, meaning register index width for rd/rs1/rs2.
REQ-004 SHALL have parameter TAGW, default 4, meaning producer tag width for t1/t2 and wb_tag.
REQ-005 SHALL define IDXW = clog2(NROWS), the row index width, and ROWW = OPW+3*REGW+2*TAGW, the row payload width.

Interface -- ports
REQ-006 SHALL have CLK, input, 1, meaning the single clock; all state on rising edge.
REQ-007 SHALL have RST, input, 1, meaning the reset: asynchronous and active-high.
REQ-008 SHALL have disp_en, input, 1, meaning dispatch request.
REQ-009 SHALL have disp_row, input, ROWW, meaning payload {op, rd, rs1, rs2, t1, t2}.
REQ-010 SHALL have disp_r1 and disp_r2, input, 1 each, meaning operand already ready at dispatch.
REQ-011 SHALL have disp_ready, output, 1, meaning at least one row is free.
REQ-012 SHALL have disp_idx, output, IDXW, meaning the row allocated when disp_en & disp_ready.
REQ-013 SHALL have wb_en, input, 1, meaning writeback broadcast valid.
REQ-014 SHALL have wb_tag, input, TAGW, meaning the tag being written back.
REQ-015 SHALL have iss_valid, output, 1, meaning a fully ready row is offered for issue.
REQ-016 SHALL have iss_ready, input, 1, meaning the issue stage accepts the offer.
REQ-017 SHALL have iss_idx, output, IDXW, meaning the offered row index.
REQ-018 SHALL have iss_row, output, ROWW, meaning the offered row payload.
REQ-019 SHALL have flush, input, 1, meaning synchronous clear of all rows.
REQ-020 SHALL have busy, output, NROWS, meaning the per-row busy vector.

Function
REQ-021 SHALL hold per row: busy, payload, r1, r2, and an age counter of IDXW bits.
REQ-022 SHALL set disp_ready = |~busy, computed from registered busy only; a row freed this cycle is not reusable until the next cycle.
REQ-023 SHALL set disp_idx to the lowest-index non-busy row.
REQ-024 SHALL, on disp_en & disp_ready, write the payload to row disp_idx, set busy=1 and age=0, and increment the age of every other busy row, saturating at NROWS-1.
REQ-025 SHALL ignore disp_en & !disp_ready, leaving no state change and generating no error.
REQ-026 SHALL, on wb_en, set r1 in every busy row with !r1 & t1==wb_tag, and set r2 likewise for t2.
REQ-027 SHALL, when wb_en coincides with a dispatch, write the dispatched row's r1 as disp_r1 | (t1==wb_tag), and r2 likewise (bypass).
REQ-028 SHALL define a row as eligible when busy & r1 & r2, using registered state; a wakeup becomes visible at issue one cycle later.
REQ-029 SHALL drive iss_valid = any row eligible, and iss_idx/iss_row = the eligible row with the largest age (oldest).
REQ-030 SHALL ensure ages of busy rows are unique, so that issue selection is deterministic.
REQ-031 SHALL, on iss_valid & iss_ready, clear busy for row iss_idx at the next edge; r1, r2 and age of that row become don't-care.
REQ-032 SHALL allow a same-cycle dispatch and issue: the issued row is freed, and the dispatch goes to disp_idx computed from the pre-issue busy vector.
REQ-033 SHALL keep iss_idx and iss_row stable while iss_valid & !iss_ready, unless an older row becomes eligible.
REQ-034 SHALL, on flush, clear all busy, r1, r2 and age bits at the next edge, overriding any same-cycle dispatch, wakeup or issue.
REQ-035 SHALL drive iss_row to zero when iss_valid=0.

Reset
REQ-036 SHALL, while RST=1 (asynchronously), clear all busy, r1, r2, age and payload bits.
REQ-037 SHALL, in reset, drive busy=0, disp_ready=1, disp_idx=0, iss_valid=0, iss_idx=0 and iss_row=0.
REQ-038 SHALL, when reset is asserted mid-operation, discard all pending rows, with no issue on the first edge after reset deasserts.

Verification
REQ-039 SHALL cover fill: 4 dispatches with r1=r2=0 -> disp_idx 0,1,2,3; busy=4'b1111; disp_ready=0; a 5th disp_en is ignored.
REQ-040 SHALL cover wakeup: row0 t1=3, t2=5; wb_tag=3, then wb_tag=5 -> iss_valid=1, iss_idx=0 one cycle after the second wb.
REQ-041 SHALL cover oldest-first: rows 2, 0, 1 dispatched in that order, all ready -> issue order 2, 0, 1 with iss_ready=1.
REQ-042 SHALL cover bypass: dispatch with t1=7, disp_r1=0, disp_r2=1 and same-cycle wb_tag=7 -> row eligible, iss_valid=1 next cycle.
REQ-043 SHALL cover stall then issue+dispatch: full table, iss_valid=1, iss_ready=0 for 3 cycles -> iss_idx stable; then iss_ready=1 with disp_en -> dispatch rejected that cycle, accepted next into the freed row.
REQ-044 SHALL cover flush/reset: flush with a concurrent dispatch -> busy=0; async RST mid-cycle -> outputs at reset values immediately.
